// File: rtl/zeroriscy_ex_fu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : zeroriscy_ex_fu_sequencer
// Brief    : EX-stage dispatch/completion control for NUM_FU functional units
//            (single-cycle or start/done multi-cycle), with watchdog and flush.
// Revision : 1.0 - initial release
// ============================================================================
module zeroriscy_ex_fu_sequencer #(
    parameter int                NUM_FU  = 3,
    parameter int                DATA_W  = 32,
    parameter logic [NUM_FU-1:0] SC_MASK = 3'b001,
    parameter int                TIMEOUT = 64,
    localparam int               FU_W    = $clog2(NUM_FU)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid_i,
    input  logic [FU_W-1:0]          issue_fu_i,
    input  logic                     flush_i,
    output logic [NUM_FU-1:0]        fu_start_o,
    output logic [NUM_FU-1:0]        fu_kill_o,
    input  logic [NUM_FU-1:0]        fu_done_i,
    input  logic [NUM_FU*DATA_W-1:0] fu_result_i,
    output logic                     wb_valid_o,
    output logic [DATA_W-1:0]        wb_data_o,
    output logic [FU_W-1:0]          wb_fu_o,
    output logic                     ex_ready_o,
    output logic                     timeout_o,
    output logic                     illegal_o
);

    localparam int              WD_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] C_WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [FU_W:0]   C_NUM_FU  = (FU_W + 1)'(NUM_FU);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            r_state, w_next_state;
    logic [FU_W-1:0]   r_cur_fu, w_next_cur_fu;
    logic [WD_W-1:0]   r_wd_cnt, w_next_wd_cnt;

    logic [FU_W-1:0]   w_sel_fu;
    logic [NUM_FU-1:0] w_sel_onehot;
    logic [DATA_W-1:0] w_sel_result;
    logic              w_sel_sc;
    logic              w_sel_done;
    logic              w_issue_legal;

    // In BUSY every lookup follows the in-flight FU; in IDLE it follows the issue.
    always_comb begin
        w_sel_fu     = (r_state == BUSY) ? r_cur_fu : issue_fu_i;
        w_sel_onehot = '0;
        w_sel_result = '0;
        w_sel_sc     = 1'b0;
        w_sel_done   = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (FU_W'(k) == w_sel_fu) begin
                w_sel_onehot[k] = 1'b1;
                w_sel_result    = fu_result_i[k*DATA_W +: DATA_W];
                w_sel_sc        = SC_MASK[k];
                w_sel_done      = fu_done_i[k];
            end
        end
    end

    assign w_issue_legal = ({1'b0, issue_fu_i} < C_NUM_FU);

    always_comb begin
        fu_start_o    = '0;
        fu_kill_o     = '0;
        wb_valid_o    = 1'b0;
        wb_data_o     = '0;
        wb_fu_o       = '0;
        ex_ready_o    = 1'b1;
        timeout_o     = 1'b0;
        illegal_o     = 1'b0;
        w_next_state  = r_state;
        w_next_cur_fu = r_cur_fu;
        w_next_wd_cnt = r_wd_cnt;
        case (r_state)
            IDLE: begin
                if (!flush_i && issue_valid_i) begin
                    if (!w_issue_legal) begin
                        illegal_o = 1'b1;
                    end else begin
                        fu_start_o = w_sel_onehot;
                        if (w_sel_sc) begin
                            wb_valid_o = 1'b1;
                            wb_data_o  = w_sel_result;
                            wb_fu_o    = issue_fu_i;
                        end else begin
                            ex_ready_o    = 1'b0;
                            w_next_state  = BUSY;
                            w_next_cur_fu = issue_fu_i;
                            w_next_wd_cnt = '0;
                        end
                    end
                end
            end
            BUSY: begin
                if (flush_i) begin
                    fu_kill_o    = w_sel_onehot;
                    ex_ready_o   = 1'b0;
                    w_next_state = IDLE;
                end else if (w_sel_done) begin
                    wb_valid_o   = 1'b1;
                    wb_data_o    = w_sel_result;
                    wb_fu_o      = r_cur_fu;
                    w_next_state = IDLE;
                end else if ((TIMEOUT != 0) && (r_wd_cnt == C_WD_LAST)) begin
                    timeout_o    = 1'b1;
                    fu_kill_o    = w_sel_onehot;
                    w_next_state = IDLE;
                end else begin
                    ex_ready_o    = 1'b0;
                    w_next_wd_cnt = r_wd_cnt + WD_W'(1);
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cur_fu <= '0;
            r_wd_cnt <= '0;
        end else begin
            r_state  <= w_next_state;
            r_cur_fu <= w_next_cur_fu;
            r_wd_cnt <= w_next_wd_cnt;
        end
    end

endmodule
`default_nettype wire

// File: doc/zeroriscy_ex_fu_sequencer.md
# zeroriscy_ex_fu_sequencer

Parametrised execute-stage dispatch and completion controller for zero-riscy. It generalises the fixed ALU/MULDIV/custom0 result-select and ready logic to NUM_FU functional units, each either single-cycle or multi-cycle with a start/done handshake. It adds a watchdog timeout and a pipeline flush on top of that. It sits between the ID stage issue signals and the functional units, and drives the register-file write-back data and `ex_ready_o`.

## Interface
- `NUM_FU`, 3: number of functional units, 2..8.
- `DATA_W`, 32: result width.
- `SC_MASK`, 3'b001: bit k set means FU k is single-cycle (combinational result).
- `TIMEOUT`, 64: maximum BUSY cycles before abort; 0 disables the watchdog.
- `FU_W`: derived, $clog2(NUM_FU); not overridable.

Ports:
- `clk` in 1: clock, one clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `issue_valid_i` in 1: ID presents an instruction this cycle.
- `issue_fu_i` in FU_W: target FU index.
- `flush_i` in 1: kill in-flight or issuing operation.
- `fu_start_o` out NUM_FU: one-cycle start pulse per FU.
- `fu_kill_o` out NUM_FU: one-cycle abort pulse per FU.
- `fu_done_i` in NUM_FU: FU result valid, 1-cycle pulse.
- `fu_result_i` in NUM_FU*DATA_W: packed results; FU k occupies bits [k*DATA_W +: DATA_W].
- `wb_valid_o` out 1: write-back valid.
- `wb_data_o` out DATA_W: write-back data.
- `wb_fu_o` out FU_W: FU that produced `wb_data_o`.
- `ex_ready_o` out 1: EX accepts a new instruction.
- `timeout_o` out 1: one-cycle pulse on watchdog abort.
- `illegal_o` out 1: one-cycle pulse when `issue_fu_i >= NUM_FU`.

## Operation
- FSM has two states, IDLE and BUSY. Registered state: `state`, `cur_fu` (FU_W), `wd_cnt` (clog2(TIMEOUT+1) bits).
- Reset sets state=IDLE, cur_fu=0, wd_cnt=0.
- Reset output values: `ex_ready_o`=1 and all other outputs 0.
- All outputs are combinational from the state registers and the inputs.

IDLE, `flush_i`=1:
- No start and no write-back.
- `ex_ready_o`=1; stay IDLE.
- Flush wins over issue.

IDLE, issue to an illegal index (`issue_fu_i >= NUM_FU`):
- `illegal_o`=1, `ex_ready_o`=1.
- No start, no write-back; stay IDLE.

IDLE, issue to FU k with SC_MASK[k]=1:
- `fu_start_o[k]`=1 and `wb_valid_o`=1.
- `wb_data_o`=fu_result_i[k], `wb_fu_o`=k.
- `ex_ready_o`=1; stay IDLE.

IDLE, issue to FU k with SC_MASK[k]=0:
- `fu_start_o[k]`=1, `ex_ready_o`=0.
- Next state BUSY with cur_fu←k and wd_cnt←0.

BUSY, checked in this priority order:
1. `flush_i`=1: `fu_kill_o[cur_fu]`=1, no write-back, `ex_ready_o`=0, go IDLE. Flush wins over a same-cycle done.
2. `fu_done_i[cur_fu]`=1: `wb_valid_o`=1, `wb_data_o`=fu_result_i[cur_fu], `wb_fu_o`=cur_fu, `ex_ready_o`=1, go IDLE. Done wins over a same-cycle timeout.
3. TIMEOUT≠0 and wd_cnt==TIMEOUT-1: `timeout_o`=1, `fu_kill_o[cur_fu]`=1, `ex_ready_o`=1, no write-back, go IDLE.
4. Otherwise: wd_cnt+1, `ex_ready_o`=0, stay BUSY.

Other rules:
- `fu_done_i` from any FU other than cur_fu, or while IDLE on a multi-cycle FU, is ignored.
- While BUSY, `issue_*` is ignored. ID must hold the instruction because `ex_ready_o`=0.
- At most one bit of `fu_start_o` and at most one bit of `fu_kill_o` is set in any cycle.
- Asserting reset mid-BUSY returns to IDLE immediately, with no kill pulse and no write-back.

## Timing
- Single-cycle FU: zero latency; issue and write-back happen in the same cycle.
- Multi-cycle FU:
  - Start in cycle 0; BUSY from cycle 1.
  - Write-back in the cycle `fu_done_i` is seen, cycle ≥1.
  - Back-to-back issue is possible in the following cycle.
- Watchdog: the last BUSY cycle is cycle TIMEOUT; `timeout_o` pulses in that cycle if no done has been seen.
- After a flush in BUSY, state is IDLE in the next cycle; `ex_ready_o`=1 from that cycle.

## Test plan
- Reset: drive rst_n=0 mid-BUSY → outputs return to reset values within the same cycle; a later `fu_done_i` is ignored.
- Single-cycle: SC_MASK=3'b001, issue FU0 with fu_result_i[0]=32'hDEADBEEF → same cycle: wb_valid=1, wb_data=DEADBEEF, wb_fu=0, fu_start=3'b001, ex_ready=1.
- Multi-cycle: issue FU1, done after 5 cycles with result 32'h12345678 → ex_ready=0 for cycles 0..4, write-back in cycle 5, a new issue is accepted in cycle 6.
- Flush: issue FU2, flush_i in cycle 3 together with fu_done_i[2] → fu_kill=3'b100, no wb_valid, IDLE in cycle 4.
- Watchdog: TIMEOUT=4, issue FU1 and never assert done → timeout_o and fu_kill[1] in cycle 4, no write-back. Repeat with done in cycle 4 → normal write-back, no timeout.
- Illegal: NUM_FU=3, issue_fu_i=3 → illegal_o=1, no start, no write-back, ex_ready=1; a stray fu_done_i[0] while IDLE produces no wb_valid.
